// File: rtl/key_receiver.sv
// key_receiver: captures a key on each rising edge of key_gen_in into a 2-entry FIFO, drops on full.
// Define KEY_RX_DUP_CHECK_EN to add the sticky dup_err output (repeat of the previous accepted key).
module key_receiver #(
  parameter int KEY_LEN_P = 128
) (
  input  logic                 clock,
  input  logic                 preset,
  input  logic [KEY_LEN_P-1:0] key_in,
  input  logic                 key_gen_in,
  input  logic                 key_ready,
  output logic                 key_valid,
  output logic [KEY_LEN_P-1:0] key_out,
  output logic [7:0]           key_count,
`ifdef KEY_RX_DUP_CHECK_EN
  output logic                 dup_err,
`endif
  output logic                 overflow
);

  logic [KEY_LEN_P-1:0] mem_r [2];
  logic                 rd_ptr_r;
  logic                 wr_ptr_r;
  logic [1:0]           occ_r;
  logic                 gen_prev_r;
  logic                 key_valid_r;
  logic [KEY_LEN_P-1:0] key_out_r;
  logic [7:0]           key_count_r;
  logic                 overflow_r;

  logic                 edge_s;
  logic                 pop_s;
  logic                 full_s;
  logic                 push_s;
  logic                 drop_s;
  logic [KEY_LEN_P-1:0] mem0_nxt_s;
  logic [KEY_LEN_P-1:0] mem1_nxt_s;
  logic                 rd_ptr_nxt_s;
  logic                 wr_ptr_nxt_s;
  logic [1:0]           occ_nxt_s;
  logic [KEY_LEN_P-1:0] head_nxt_s;

  // Next buffer state; the registered head is loaded from it so key_out tracks the FIFO with latency 1.
  always_comb begin
    edge_s       = key_gen_in & ~gen_prev_r;
    pop_s        = key_valid_r & key_ready;
    full_s       = (occ_r == 2'd2);
    push_s       = edge_s & (~full_s | pop_s);
    drop_s       = edge_s & full_s & ~pop_s;
    rd_ptr_nxt_s = rd_ptr_r ^ pop_s;
    wr_ptr_nxt_s = wr_ptr_r ^ push_s;
    if (push_s && (wr_ptr_r == 1'b0)) begin
      mem0_nxt_s = key_in;
    end else begin
      mem0_nxt_s = mem_r[0];
    end
    if (push_s && (wr_ptr_r == 1'b1)) begin
      mem1_nxt_s = key_in;
    end else begin
      mem1_nxt_s = mem_r[1];
    end
    case ({push_s, pop_s})
      2'b10:   occ_nxt_s = occ_r + 2'd1;
      2'b01:   occ_nxt_s = occ_r - 2'd1;
      default: occ_nxt_s = occ_r;
    endcase
    if (rd_ptr_nxt_s) begin
      head_nxt_s = mem1_nxt_s;
    end else begin
      head_nxt_s = mem0_nxt_s;
    end
  end

  // FIFO storage, pointers, edge history, registered outputs and the sticky overflow flag.
  always_ff @(posedge clock) begin
    if (preset) begin
      mem_r[0]    <= '0;
      mem_r[1]    <= '0;
      rd_ptr_r    <= 1'b0;
      wr_ptr_r    <= 1'b0;
      occ_r       <= 2'd0;
      gen_prev_r  <= 1'b0;
      key_valid_r <= 1'b0;
      key_out_r   <= '0;
      key_count_r <= 8'd0;
      overflow_r  <= 1'b0;
    end else begin
      mem_r[0]    <= mem0_nxt_s;
      mem_r[1]    <= mem1_nxt_s;
      rd_ptr_r    <= rd_ptr_nxt_s;
      wr_ptr_r    <= wr_ptr_nxt_s;
      occ_r       <= occ_nxt_s;
      gen_prev_r  <= key_gen_in;
      key_valid_r <= (occ_nxt_s != 2'd0);
      key_out_r   <= head_nxt_s;
      if (push_s) begin
        key_count_r <= key_count_r + 8'd1;
      end else begin
        key_count_r <= key_count_r;
      end
      overflow_r  <= overflow_r | drop_s;
    end
  end

  assign key_valid = key_valid_r;
  assign key_out   = key_out_r;
  assign key_count = key_count_r;
  assign overflow  = overflow_r;

`ifdef KEY_RX_DUP_CHECK_EN
  logic [KEY_LEN_P-1:0] last_key_r;
  logic                 dup_err_r;

  // Compare each accepted key against the previous accepted one; flag stays set until preset.
  always_ff @(posedge clock) begin
    if (preset) begin
      last_key_r <= '0;
      dup_err_r  <= 1'b0;
    end else if (push_s) begin
      last_key_r <= key_in;
      dup_err_r  <= dup_err_r | (key_in == last_key_r);
    end else begin
      last_key_r <= last_key_r;
      dup_err_r  <= dup_err_r;
    end
  end

  assign dup_err = dup_err_r;
`endif

endmodule
